matmul_mem_sequencer: RTL and testbench
=======================================

MATMUL_MEM_SEQUENCER -- requirements
Module: matmul_mem_sequencer

Interface
REQ-001 SHALL have parameter N, default 3, meaning the matrix dimension (N x N).
REQ-002 SHALL have parameter BASE_A, default 32'h0000_0200, meaning the byte base address of operand matrix A.
REQ-003 SHALL have parameter BASE_B, default 32'h0000_0300, meaning the byte base address of operand matrix B.
REQ-004 SHALL have parameter BASE_C, default 32'h0000_0100, meaning the byte base address of result matrix C.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port start, input, 1 bit: request one multiply.
REQ-008 SHALL have port busy, output, 1 bit: high while the operation is in progress (state not IDLE).
REQ-009 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port memread, output, 1 bit: memory read strobe.
REQ-011 SHALL have port memwrite, output, 1 bit: memory write strobe.
REQ-012 SHALL have port address, output, 32 bits: byte address to main memory.
REQ-013 SHALL have port data_out, output, 32 bits: write data to memory (memory data_in).
REQ-014 SHALL have port data_in, input, 32 bits: read data from memory (memory data_out), valid combinationally in the same cycle as address.

Function
REQ-015 SHALL compute C = A x B, row-major, element (r,c) at BASE + 4*(r*N + c).
REQ-016 SHALL implement states IDLE, RD_A, RD_B, WR_C, DONE.
REQ-017 IDLE: start high at an edge SHALL go to RD_A with i=j=k=0 and acc=0; start low SHALL stay in IDLE.
REQ-018 RD_A SHALL drive memread=1, address=BASE_A+4*(i*N+k), latch data_in into a_reg, then go to RD_B.
REQ-019 RD_B SHALL drive memread=1, address=BASE_B+4*(k*N+j), and perform acc <= acc + a_reg*data_in.
REQ-020 From RD_B: if k<N-1, k++ and go to RD_A; otherwise go to WR_C.
REQ-021 WR_C SHALL drive memwrite=1, address=BASE_C+4*(i*N+j), data_out=acc, then clear acc and k and advance j, then i (row-major).
REQ-022 After the WR_C of element (N-1,N-1), SHALL go to DONE, assert done for exactly one cycle, then go to IDLE.
REQ-023 Latency for N=3: 63 busy cycles (9 elements x 7 cycles), with done high in cycle 64 after the start-sampling edge.
REQ-024 memread and memwrite SHALL never be high together; in IDLE and DONE both SHALL be 0, and address and data_out SHALL be 0.
REQ-025 start asserted while busy SHALL be ignored and SHALL NOT be queued.
REQ-026 Product: SHALL be unsigned 32x32; only the low 32 bits are used unless saturation is enabled (REQ-030).
REQ-027 acc SHALL be 32-bit unsigned.

Reset
REQ-028 On rst_n low, immediately and regardless of state: state=IDLE; i, j, k, acc and a_reg SHALL be 0; busy, done, memread and memwrite SHALL be 0; address and data_out SHALL be 0.
REQ-029 Reset mid-operation SHALL abandon the multiply with no further memory write; a new start after reset release SHALL restart at element (0,0).

Configuration
REQ-030 With MATMUL_ACC_SAT_EN defined: the full 64-bit product plus acc SHALL be computed, and any value above 32'hFFFF_FFFF SHALL clamp acc to 32'hFFFF_FFFF.
REQ-031 Without MATMUL_ACC_SAT_EN: acc SHALL wrap modulo 2^32.

Structure
REQ-032 Package matmul_seq_pkg SHALL hold the state enum type, the default N, BASE_A/BASE_B/BASE_C and the word stride constant (4).
REQ-033 The multiply-accumulate (including the saturation option) SHALL be a sub-module matmul_mac; index counters and the FSM SHALL stay in the top.

Verification
REQ-034 A=1..9, B=identity, one start pulse -> writes to 0x100..0x120 of 1..9 in order; done in cycle 64.
REQ-035 A=1..9, B=all 1 -> C rows 6,6,6 / 15,15,15 / 24,24,24.
REQ-036 Start re-pulsed at cycle 10 and held high until done -> exactly 9 writes, one done pulse, and a second operation only if start is high in IDLE.
REQ-037 rst_n low at cycle 30 -> all outputs 0 immediately, no write after reset; a later start gives the full correct result.
REQ-038 A row 0 = 32'hFFFF_FFFF, B all 1 -> C[0][*]=32'hFFFF_FFFD without MATMUL_ACC_SAT_EN, 32'hFFFF_FFFF with it.
REQ-039 Every cycle: assertion that memread and memwrite are not both high, and that address is word-aligned whenever a strobe is high.

Source files
------------

// File: rtl/matmul_seq_pkg.sv
// -----------------------------------------------------------------------------
// matmul_seq_pkg
//   Shared definitions for the matrix-multiply memory sequencer:
//     - state_t        : sequencer FSM state encoding
//     - DEFAULT_N      : default matrix dimension
//     - DEFAULT_BASE_* : default byte base addresses of A, B and C
//     - WORD_BYTES     : byte stride between consecutive matrix elements
//     - elem_addr()    : row-major byte address of element (row, col)
// -----------------------------------------------------------------------------
package matmul_seq_pkg;

    localparam int          DEFAULT_N      = 3;
    localparam logic [31:0] DEFAULT_BASE_A = 32'h0000_0200;
    localparam logic [31:0] DEFAULT_BASE_B = 32'h0000_0300;
    localparam logic [31:0] DEFAULT_BASE_C = 32'h0000_0100;
    localparam logic [31:0] WORD_BYTES     = 32'd4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_B = 3'd2,
        WR_C = 3'd3,
        DONE = 3'd4
    } state_t;

    // Row-major element address: base + 4*(row*n + col).
    function automatic logic [31:0] elem_addr(input logic [31:0] base,
                                              input logic [31:0] row,
                                              input logic [31:0] col,
                                              input int          n);
        return base + WORD_BYTES * (row * 32'(n) + col);
    endfunction

endpackage

// File: rtl/matmul_mac.sv
// -----------------------------------------------------------------------------
// matmul_mac
//   32-bit unsigned multiply-accumulate register used by the sequencer.
//   Optional build macro: MATMUL_ACC_SAT_EN
//     defined   : full 64-bit product plus acc, clamped to 32'hFFFF_FFFF
//     undefined : low 32 bits of the product, acc wraps modulo 2^32
//
//   Ports
//     clk    in   clock, rising edge
//     rst_n  in   asynchronous active-low reset (acc -> 0)
//     clr    in   synchronous clear of acc (wins over en)
//     en     in   accumulate a*b into acc this cycle
//     a, b   in   32-bit unsigned operands
//     acc    out  32-bit accumulator
// -----------------------------------------------------------------------------
module matmul_mac (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] acc
);

    logic [31:0] acc_next;

`ifdef MATMUL_ACC_SAT_EN
    // (2^32-1)^2 + (2^32-1) still fits in 64 bits, so no carry is lost.
    logic [63:0] sum_wide;
    assign sum_wide = {32'd0, acc} + ({32'd0, a} * {32'd0, b});
    assign acc_next = (|sum_wide[63:32]) ? 32'hFFFF_FFFF : sum_wide[31:0];
`else
    assign acc_next = acc + (a * b);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= 32'd0;
        end else if (clr) begin
            acc <= 32'd0;
        end else if (en) begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/matmul_mem_sequencer.sv
// -----------------------------------------------------------------------------
// matmul_mem_sequencer
//   Computes C = A x B (N x N, 32-bit unsigned, row-major) by walking a single
//   memory port: for each C element it reads A[i][k] then B[k][j] for every k,
//   accumulates, then writes C[i][j]. Seven cycles per element for N=3.
//   Optional build macro: MATMUL_ACC_SAT_EN (saturating accumulate, see
//   matmul_mac).
//
//   Memory handshake: one access per cycle. memread/memwrite are mutually
//   exclusive strobes; address/data_out are valid in the strobe cycle and
//   data_in must be valid combinationally in that same cycle. When no strobe
//   is high, address and data_out are driven to 0.
//
//   Ports
//     clk       in   clock, rising edge
//     rst_n     in   asynchronous active-low reset
//     start     in   request one multiply (sampled only in IDLE)
//     busy      out  high whenever the FSM is not IDLE
//     done      out  one-cycle completion pulse
//     memread   out  memory read strobe
//     memwrite  out  memory write strobe
//     address   out  32-bit byte address
//     data_out  out  write data (accumulated C element)
//     data_in   in   read data from memory
// -----------------------------------------------------------------------------
module matmul_mem_sequencer
    import matmul_seq_pkg::*;
#(
    parameter int          N      = DEFAULT_N,
    parameter logic [31:0] BASE_A = DEFAULT_BASE_A,
    parameter logic [31:0] BASE_B = DEFAULT_BASE_B,
    parameter logic [31:0] BASE_C = DEFAULT_BASE_C
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        memread,
    output logic        memwrite,
    output logic [31:0] address,
    output logic [31:0] data_out,
    input  logic [31:0] data_in
);

    localparam int               IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] ONE   = IDX_W'(1);

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] i;
    logic [IDX_W-1:0] j;
    logic [IDX_W-1:0] k;
    logic [31:0]      a_reg;
    logic             mac_clr;
    logic             mac_en;
    logic [31:0]      acc;

    matmul_mac u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (mac_clr),
        .en    (mac_en),
        .a     (a_reg),
        .b     (data_in),
        .acc   (acc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Index counters and the A operand latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i     <= '0;
            j     <= '0;
            k     <= '0;
            a_reg <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        i <= '0;
                        j <= '0;
                        k <= '0;
                    end
                end
                RD_A: begin
                    a_reg <= data_in;
                end
                RD_B: begin
                    if (k != LAST) begin
                        k <= k + ONE;
                    end
                end
                WR_C: begin
                    k <= '0;
                    if (j == LAST) begin
                        j <= '0;
                        // After the final element i wraps to 0, leaving a
                        // clean start point for the next run.
                        i <= (i == LAST) ? '0 : i + ONE;
                    end else begin
                        j <= j + ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_next = state;
        memread    = 1'b0;
        memwrite   = 1'b0;
        address    = 32'd0;
        data_out   = 32'd0;
        done       = 1'b0;
        mac_clr    = 1'b0;
        mac_en     = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    mac_clr    = 1'b1;
                    state_next = RD_A;
                end
            end
            RD_A: begin
                memread    = 1'b1;
                address    = elem_addr(BASE_A, 32'(i), 32'(k), N);
                state_next = RD_B;
            end
            RD_B: begin
                memread    = 1'b1;
                address    = elem_addr(BASE_B, 32'(k), 32'(j), N);
                mac_en     = 1'b1;
                state_next = (k == LAST) ? WR_C : RD_A;
            end
            WR_C: begin
                memwrite   = 1'b1;
                address    = elem_addr(BASE_C, 32'(i), 32'(j), N);
                data_out   = acc;
                mac_clr    = 1'b1;
                state_next = ((i == LAST) && (j == LAST)) ? DONE : RD_A;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_matmul_mem_sequencer.sv
// -----------------------------------------------------------------------------
// tb_matmul_mem_sequencer
//   Table-driven bench for matmul_mem_sequencer (N=3, default bases) with a
//   word-array memory model, a write scoreboard and hand-written sequences for
//   start-while-busy and mid-operation reset.
// -----------------------------------------------------------------------------
module tb_matmul_mem_sequencer;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic        done;
    logic        memread;
    logic        memwrite;
    logic [31:0] address;
    logic [31:0] data_out;
    logic [31:0] data_in;

    always #5 clk = ~clk;

    matmul_mem_sequencer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .memread  (memread),
        .memwrite (memwrite),
        .address  (address),
        .data_out (data_out),
        .data_in  (data_in)
    );

    // ---------------- memory model ----------------
    // Word index = byte address >> 2; C at 64.., A at 128.., B at 192..
    logic [31:0] mem [0:255];
    assign data_in = mem[address[9:2]];

    // ---------------- vectors ----------------
    typedef struct packed {
        logic [8:0][31:0] a;
        logic [8:0][31:0] b;
        logic [8:0][31:0] c;
    } vec_t;

    vec_t vecs [4];

`ifdef MATMUL_ACC_SAT_EN
    localparam logic [31:0] ROW0_OVF = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] ROW0_OVF = 32'hFFFF_FFFD;
`endif

    int m3a [9] = '{2, 0, 1, 3, 1, 0, 0, 4, 5};
    int m3b [9] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    int m3c [9] = '{9, 12, 15, 7, 11, 15, 51, 60, 69};

    // ---------------- scoreboard ----------------
    logic [63:0] exp_q [$];
    logic [63:0] got_q [$];
    int          done_cnt;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // One cycle: wait for the falling edge, then run protocol checks and
    // capture any write strobe.
    task automatic tick();
        @(negedge clk);
        chk("strobe_exclusive", {63'd0, memread & memwrite}, 64'd0);
        if (memread || memwrite)
            chk("addr_aligned", {62'd0, address[1:0]}, 64'd0);
        if (!busy)
            chk("idle_quiet", {28'd0, done, memread, memwrite, (address != 0 || data_out != 0)}, 64'd0);
        if (rst_n) begin
            if (memwrite) begin
                got_q.push_back({address, data_out});
                mem[address[9:2]] = data_out;
            end
            if (done) done_cnt++;
        end
    endtask

    task automatic load_vec(input int v);
        for (int e = 0; e < 9; e++) begin
            mem[64 + e]  = 32'd0;
            mem[128 + e] = vecs[v].a[e];
            mem[192 + e] = vecs[v].b[e];
        end
        got_q.delete();
        exp_q.delete();
        done_cnt = 0;
        for (int e = 0; e < 9; e++)
            exp_q.push_back({32'h100 + 32'(4 * e), vecs[v].c[e]});
    endtask

    task automatic compare_writes();
        chk("write_count", 64'(got_q.size()), 64'd9);
        for (int e = 0; e < 9; e++) begin
            if (e < got_q.size())
                chk($sformatf("write_%0d", e), got_q[e], exp_q[e]);
        end
    endtask

    task automatic run_op(input int v);
        int cyc;
        load_vec(v);
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        chk("busy_cycle1", {63'd0, busy}, 64'd1);
        while (!done && cyc < 200) begin
            tick();
            cyc++;
        end
        chk($sformatf("done_cycle_v%0d", v), 64'(cyc), 64'd64);
        tick();
        chk("idle_after_done", {63'd0, busy}, 64'd0);
        chk("done_pulses", 64'(done_cnt), 64'd1);
        compare_writes();
    endtask

    // ---------------- test ----------------
    initial begin
        int cyc;

        for (int e = 0; e < 256; e++) mem[e] = 32'd0;
        for (int e = 0; e < 9; e++) begin
            vecs[0].a[e] = 32'(e + 1);
            vecs[0].b[e] = (e % 4 == 0) ? 32'd1 : 32'd0;
            vecs[0].c[e] = 32'(e + 1);
            vecs[1].a[e] = 32'(e + 1);
            vecs[1].b[e] = 32'd1;
            vecs[1].c[e] = (e < 3) ? 32'd6 : ((e < 6) ? 32'd15 : 32'd24);
            vecs[2].a[e] = (e < 3) ? 32'hFFFF_FFFF : 32'(e + 1);
            vecs[2].b[e] = 32'd1;
            vecs[2].c[e] = (e < 3) ? ROW0_OVF : ((e < 6) ? 32'd15 : 32'd24);
            vecs[3].a[e] = 32'(m3a[e]);
            vecs[3].b[e] = 32'(m3b[e]);
            vecs[3].c[e] = 32'(m3c[e]);
        end

        // Reset state
        rst_n = 1'b0;
        start = 1'b0;
        done_cnt = 0;
        repeat (3) tick();
        chk("reset_outputs", {busy, done, memread, memwrite, address, data_out}, 68'd0);
        rst_n = 1'b1;
        tick();

        // Table-driven vectors
        for (int v = 0; v < 4; v++) run_op(v);

        // start re-asserted at cycle 10 and held until done: ignored, not queued
        load_vec(0);
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (cyc < 10) begin
            tick();
            cyc++;
        end
        start = 1'b1;
        while (!done && cyc < 200) begin
            tick();
            cyc++;
        end
        start = 1'b0;
        chk("rep_done_cycle", 64'(cyc), 64'd64);
        for (int n = 0; n < 5; n++) begin
            tick();
            chk("rep_stays_idle", {63'd0, busy}, 64'd0);
        end
        chk("rep_done_pulses", 64'(done_cnt), 64'd1);
        compare_writes();

        // Reset at cycle 30: outputs clear at once, no further writes
        load_vec(3);
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        while (cyc < 30) begin
            tick();
            cyc++;
        end
        rst_n = 1'b0;
        #1;
        chk("midreset_outputs", {busy, done, memread, memwrite, address, data_out}, 68'd0);
        chk("midreset_writes", 64'(got_q.size()), 64'd4);
        repeat (3) tick();
        rst_n = 1'b1;
        for (int n = 0; n < 10; n++) tick();
        chk("postreset_no_write", 64'(got_q.size()), 64'd4);
        chk("postreset_idle", {63'd0, busy}, 64'd0);
        run_op(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
